// File: rtl/fir_chirp_ctrl.sv
// fir_chirp_ctrl: chirp/frame sequencer in front of fir_filter.
// Gates mixer samples into the FIR inside each chirp's sampling window, counts
// FIR outputs, drops the filter start-up transient and tags the rest with
// frame/chirp markers. Flags chirp_sync pulses that arrive mid-chirp.
//
// Handshakes: adc_valid is a single-cycle strobe with no back-pressure; a sample
// is taken on each edge where adc_valid is high in FEED. fir_ready is the
// matching one-cycle strobe toward the FIR, 1 cycle after the accepted
// adc_valid. fir_valid is likewise a strobe, and out_valid follows it 1 cycle
// later; neither side can stall the other.
module fir_chirp_ctrl #(
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 28,
  parameter int SAMPLES   = 1024,
  parameter int SKIP      = 63,
  parameter int CHIRPS    = 64,
  localparam int CW       = (CHIRPS > 1) ? $clog2(CHIRPS) : 1,
  localparam int NW       = $clog2(SAMPLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 chirp_sync,
  input  logic                 adc_valid,
  input  logic [WIDTH-1:0]     adc_data,
  output logic                 fir_ready,
  output logic [WIDTH-1:0]     fir_mix_data,
  input  logic                 fir_valid,
  input  logic [OUT_WIDTH-1:0] fir_data,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_sof,
  output logic                 out_sol,
  output logic                 out_eol,
  output logic [CW-1:0]        chirp_idx,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 sync_err,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    FEED      = 2'd2,
    DRAIN     = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [NW-1:0] in_cnt, out_cnt;
  logic          in_take;     // sample accepted on this edge
  logic          out_take;    // FIR output counted on this edge
  logic          drain_done;  // last FIR output of the chirp counted
  logic          last_chirp;
  logic          fwd;         // counted output lies past the transient

  assign last_chirp = (chirp_idx == CW'(CHIRPS - 1));
  assign fwd        = out_take && (out_cnt >= NW'(SKIP));
  assign dbg_state  = state_q;

  // Next-state and per-edge qualifiers; stop overrides everything.
  always_comb begin
    state_d    = state_q;
    in_take    = 1'b0;
    out_take   = 1'b0;
    drain_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = WAIT_SYNC;
      end
      WAIT_SYNC: begin
        if (chirp_sync) state_d = FEED;
      end
      FEED: begin
        in_take = adc_valid;
        if (adc_valid && (in_cnt == NW'(SAMPLES - 1))) state_d = DRAIN;
      end
      DRAIN: begin
        if ((out_cnt == NW'(SAMPLES)) ||
            (fir_valid && (out_cnt == NW'(SAMPLES - 1)))) begin
          drain_done = 1'b1;
          state_d    = last_chirp ? IDLE : WAIT_SYNC;
        end
      end
      default: state_d = IDLE;
    endcase
    // FIR outputs overlap the input phase, so they are counted in FEED too.
    // Saturating at SAMPLES keeps the counter from wrapping within a chirp.
    out_take = fir_valid && ((state_q == FEED) || (state_q == DRAIN)) &&
               (out_cnt < NW'(SAMPLES));
    if (stop) begin
      state_d    = IDLE;
      in_take    = 1'b0;
      out_take   = 1'b0;
      drain_done = 1'b0;
    end
  end

  // State register; busy is registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
    end
  end

  // Per-chirp input/output counters and the chirp index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt    <= '0;
      out_cnt   <= '0;
      chirp_idx <= '0;
    end else if (stop) begin
      in_cnt    <= '0;
      out_cnt   <= '0;
      chirp_idx <= '0;
    end else begin
      if ((state_q == IDLE) && start) chirp_idx <= '0;
      if ((state_q == WAIT_SYNC) && chirp_sync) begin
        in_cnt  <= '0;
        out_cnt <= '0;
      end
      if (in_take)  in_cnt  <= in_cnt + NW'(1);
      if (out_take) out_cnt <= out_cnt + NW'(1);
      if (drain_done && !last_chirp) chirp_idx <= chirp_idx + CW'(1);
    end
  end

  // Input path: one-cycle ready strobe plus the sample it carries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fir_ready    <= 1'b0;
      fir_mix_data <= '0;
    end else begin
      fir_ready <= in_take;
      if (in_take) fir_mix_data <= adc_data;
    end
  end

  // Output path: forward post-transient FIR outputs with their tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sof    <= 1'b0;
      out_sol    <= 1'b0;
      out_eol    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= fwd;
      out_sol    <= fwd && (out_cnt == NW'(SKIP));
      out_eol    <= fwd && (out_cnt == NW'(SAMPLES - 1));
      out_sof    <= fwd && (out_cnt == NW'(SKIP)) && (chirp_idx == '0);
      frame_done <= drain_done && last_chirp;
      if (fwd) out_data <= fir_data;
    end
  end

  // Sticky sync error: a chirp_sync while a chirp is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_err <= 1'b0;
    end else if (!stop) begin
      if ((state_q == IDLE) && start) begin
        sync_err <= 1'b0;
      end else if (((state_q == FEED) || (state_q == DRAIN)) && chirp_sync) begin
        sync_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_chirp_ctrl.sv
// tb_fir_chirp_ctrl: frame-level checks of fir_chirp_ctrl with a latency-4
// echo FIR stub, a table of frame scenarios, hand-written reset/ignore
// sequences and randomized frames.
module tb_fir_chirp_ctrl;

  localparam int WIDTH     = 16;
  localparam int OUT_WIDTH = 28;
  localparam int SAMPLES   = 8;
  localparam int SKIP      = 3;
  localparam int CHIRPS    = 2;
  localparam int CW        = 1;
  localparam int NVEC      = 6;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 start = 1'b0, stop = 1'b0, chirp_sync = 1'b0, adc_valid = 1'b0;
  logic [WIDTH-1:0]     adc_data = '0;
  logic                 fir_ready;
  logic [WIDTH-1:0]     fir_mix_data;
  logic                 fir_valid;
  logic [OUT_WIDTH-1:0] fir_data;
  logic                 out_valid, out_sof, out_sol, out_eol;
  logic [OUT_WIDTH-1:0] out_data;
  logic [CW-1:0]        chirp_idx;
  logic                 busy, frame_done, sync_err;
  logic [1:0]           dbg_state;

  fir_chirp_ctrl #(
    .WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH), .SAMPLES(SAMPLES), .SKIP(SKIP), .CHIRPS(CHIRPS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .chirp_sync(chirp_sync),
    .adc_valid(adc_valid), .adc_data(adc_data), .fir_ready(fir_ready),
    .fir_mix_data(fir_mix_data), .fir_valid(fir_valid), .fir_data(fir_data),
    .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_sol(out_sol),
    .out_eol(out_eol), .chirp_idx(chirp_idx), .busy(busy), .frame_done(frame_done),
    .sync_err(sync_err), .dbg_state(dbg_state)
  );

  function automatic logic [OUT_WIDTH-1:0] sext(input logic [WIDTH-1:0] v);
    return {{(OUT_WIDTH-WIDTH){v[WIDTH-1]}}, v};
  endfunction

  // ---------------- FIR stub: echo with latency 4 ----------------
  logic             pipe_v [4];
  logic [WIDTH-1:0] pipe_d [4];
  logic             inj_v = 1'b0;
  logic [WIDTH-1:0] inj_d = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_d[i] <= '0;
      end
    end else begin
      pipe_v[0] <= fir_ready;
      pipe_d[0] <= fir_mix_data;
      for (int i = 1; i < 4; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign fir_valid = pipe_v[3] | inj_v;
  assign fir_data  = inj_v ? sext(inj_d) : sext(pipe_d[3]);

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [OUT_WIDTH-1:0] data;
    logic                 sof;
    logic                 sol;
    logic                 eol;
    logic                 done;
    logic [CW-1:0]        chirp;
  } exp_t;

  logic [WIDTH-1:0] exp_q[$];   // samples expected on fir_mix_data, in order
  exp_t             out_q[$];   // tagged outputs expected on out_data, in order

  int checks = 0;
  int errors = 0;
  int cnt_out = 0, cnt_done = 0, cnt_ready = 0, eol_seen = 0;
  logic mon_en = 1'b0;
  logic expect_take = 1'b0;
  logic take_at_edge = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // What the DUT was offered on each edge, for the 1-cycle ready check.
  always @(posedge clk) take_at_edge <= adc_valid && expect_take;

  exp_t             mo;
  logic [WIDTH-1:0] me;

  // Monitor: sample outputs at the falling edge and compare to the queues.
  always @(negedge clk) begin
    if (mon_en) begin
      check("fir_ready_timing", 64'(fir_ready), 64'(take_at_edge));
      if (fir_ready) begin
        cnt_ready++;
        if (exp_q.size() == 0) begin
          check("fir_ready_extra", 64'(fir_mix_data), 64'hdead);
        end else begin
          me = exp_q.pop_front();
          check("fir_mix_data", 64'(fir_mix_data), 64'(me));
        end
      end
      if (out_valid) begin
        cnt_out++;
        if (out_eol) eol_seen++;
        if (out_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_extra: got out_valid with data %0h, expected none", out_data);
        end else begin
          mo = out_q.pop_front();
          check("out_data", 64'(out_data), 64'(mo.data));
          check("out_sof", 64'(out_sof), 64'(mo.sof));
          check("out_sol", 64'(out_sol), 64'(mo.sol));
          check("out_eol", 64'(out_eol), 64'(mo.eol));
          check("frame_done_at_eol", 64'(frame_done), 64'(mo.done));
          if (mo.sol) check("chirp_idx_at_sol", 64'(chirp_idx), 64'(mo.chirp));
        end
      end else begin
        check("frame_done_quiet", 64'(frame_done), 64'(0));
      end
      if (frame_done) cnt_done++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_sync();
    chirp_sync = 1'b1;
    tick();
    chirp_sync = 1'b0;
  endtask

  typedef struct {
    int gap;          // idle cycles before every sample
    bit ramp;         // samples 1..SAMPLES instead of random
    bit extra_sync;   // extra chirp_sync at sample 2 of chirp 0
    bit start_mid;    // start pulse at sample 4 of each chirp
    bit stray;        // stray fir_valid in WAIT_SYNC before each chirp
    int stop_chirp;   // chirp in which stop is raised (-1: none)
    int stop_at;      // sample index that coincides with stop
    int exp_outs;
    int exp_done;
    bit exp_err;
    int exp_ready;
  } vec_t;

  task automatic run_frame(input vec_t v, input string tag);
    bit   stopped;
    bit   take;
    int   guard;
    cnt_out = 0; cnt_done = 0; cnt_ready = 0; eol_seen = 0;
    pulse_start();
    check({tag, ":busy_after_start"}, 64'(busy), 64'(1));
    check({tag, ":sync_err_cleared"}, 64'(sync_err), 64'(0));
    check({tag, ":chirp_idx_start"}, 64'(chirp_idx), 64'(0));
    for (int c = 0; c < CHIRPS; c++) begin
      if (v.stray) begin
        inj_d = WIDTH'($urandom);
        inj_v = 1'b1;
        tick();
        tick();
        inj_v = 1'b0;
      end
      repeat ($urandom_range(0, 2)) tick();
      pulse_sync();
      check($sformatf("%s:chirp_idx_c%0d", tag, c), 64'(chirp_idx), 64'(c));
      stopped = 1'b0;
      for (int i = 0; i < SAMPLES; i++) begin
        repeat (v.gap) tick();
        adc_valid = 1'b1;
        adc_data  = v.ramp ? WIDTH'(i + 1) : WIDTH'($urandom);
        take = !((v.stop_chirp == c) && (v.stop_at == i));
        if (take) begin
          expect_take = 1'b1;
          exp_q.push_back(adc_data);
          if ((i >= SKIP) && (v.stop_chirp != c)) begin
            out_q.push_back('{data: sext(adc_data), sof: (c == 0) && (i == SKIP),
                              sol: (i == SKIP), eol: (i == SAMPLES - 1),
                              done: (i == SAMPLES - 1) && (c == CHIRPS - 1),
                              chirp: CW'(c)});
          end
        end else begin
          stop = 1'b1;
        end
        if (v.extra_sync && (c == 0) && (i == 2)) chirp_sync = 1'b1;
        if (v.start_mid && (i == 4)) start = 1'b1;
        tick();
        adc_valid = 1'b0; expect_take = 1'b0; chirp_sync = 1'b0; start = 1'b0;
        if (!take) begin
          stop = 1'b0;
          check({tag, ":busy_after_stop"}, 64'(busy), 64'(0));
          check({tag, ":fir_ready_after_stop"}, 64'(fir_ready), 64'(0));
          stopped = 1'b1;
          break;
        end
      end
      if (stopped) break;
      guard = 0;
      while ((eol_seen < c + 1) && (guard < 300)) begin
        tick();
        guard++;
      end
      check($sformatf("%s:drain_c%0d_in_time", tag, c), 64'(eol_seen >= c + 1), 64'(1));
      repeat ($urandom_range(1, 3)) tick();
    end
    repeat (12) tick();
    check({tag, ":out_count"}, 64'(cnt_out), 64'(v.exp_outs));
    check({tag, ":frame_done_count"}, 64'(cnt_done), 64'(v.exp_done));
    check({tag, ":ready_count"}, 64'(cnt_ready), 64'(v.exp_ready));
    check({tag, ":sync_err"}, 64'(sync_err), 64'(v.exp_err));
    check({tag, ":busy_end"}, 64'(busy), 64'(0));
    check({tag, ":samples_left"}, 64'(exp_q.size()), 64'(0));
    check({tag, ":outputs_left"}, 64'(out_q.size()), 64'(0));
    exp_q.delete();
    out_q.delete();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    $display("FAIL watchdog: got no end of test, expected finish within time limit");
    $fatal(1);
  end

  // ---------------- main test ----------------
  vec_t vecs [NVEC];
  vec_t rv;

  initial begin
    //            gap ramp xs  sm  st  stop_c stop_at outs done err ready
    vecs[0] = '{gap:0, ramp:1, extra_sync:0, start_mid:0, stray:0, stop_chirp:-1, stop_at:0,
                exp_outs:10, exp_done:1, exp_err:0, exp_ready:16};
    vecs[1] = '{gap:2, ramp:0, extra_sync:0, start_mid:0, stray:0, stop_chirp:-1, stop_at:0,
                exp_outs:10, exp_done:1, exp_err:0, exp_ready:16};
    vecs[2] = '{gap:0, ramp:0, extra_sync:1, start_mid:0, stray:0, stop_chirp:-1, stop_at:0,
                exp_outs:10, exp_done:1, exp_err:1, exp_ready:16};
    vecs[3] = '{gap:1, ramp:0, extra_sync:0, start_mid:1, stray:1, stop_chirp:-1, stop_at:0,
                exp_outs:10, exp_done:1, exp_err:0, exp_ready:16};
    vecs[4] = '{gap:0, ramp:1, extra_sync:0, start_mid:0, stray:0, stop_chirp:1, stop_at:4,
                exp_outs:5, exp_done:0, exp_err:0, exp_ready:12};
    vecs[5] = '{gap:0, ramp:1, extra_sync:0, start_mid:0, stray:0, stop_chirp:-1, stop_at:0,
                exp_outs:10, exp_done:1, exp_err:0, exp_ready:16};

    // Reset values.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst:flags", 64'({fir_ready, out_valid, out_sof, out_sol, out_eol, busy, frame_done, sync_err}), 64'(0));
    check("rst:out_data", 64'(out_data), 64'(0));
    check("rst:fir_mix_data", 64'(fir_mix_data), 64'(0));
    check("rst:chirp_idx", 64'(chirp_idx), 64'(0));
    rst_n = 1'b1;
    tick();

    // chirp_sync in IDLE is ignored with no error.
    pulse_sync();
    check("idle_sync:busy", 64'(busy), 64'(0));
    check("idle_sync:sync_err", 64'(sync_err), 64'(0));
    tick();

    mon_en = 1'b1;
    for (int n = 0; n < NVEC; n++) begin
      run_frame(vecs[n], $sformatf("vec%0d", n));
    end

    // Asynchronous reset in the middle of DRAIN.
    mon_en = 1'b0;
    pulse_start();
    pulse_sync();
    for (int i = 0; i < SAMPLES; i++) begin
      adc_valid = 1'b1;
      adc_data  = WIDTH'(i + 1);
      tick();
    end
    adc_valid = 1'b0;
    tick();
    tick();
    check("pre_rst:busy", 64'(busy), 64'(1));
    check("pre_rst:out_data_live", 64'(out_data != '0), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst:flags", 64'({fir_ready, out_valid, out_sof, out_sol, out_eol, busy, frame_done, sync_err}), 64'(0));
    check("async_rst:out_data", 64'(out_data), 64'(0));
    check("async_rst:fir_mix_data", 64'(fir_mix_data), 64'(0));
    check("async_rst:chirp_idx", 64'(chirp_idx), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      inj_d = WIDTH'($urandom);
      inj_v = 1'b1;
      tick();
      check($sformatf("post_rst:stray_out_valid%0d", k), 64'(out_valid), 64'(0));
    end
    inj_v = 1'b0;
    tick();
    check("post_rst:busy", 64'(busy), 64'(0));
    exp_q.delete();
    out_q.delete();
    mon_en = 1'b1;

    // Randomized frames against the scoreboard.
    for (int n = 0; n < 6; n++) begin
      rv.gap        = $urandom_range(0, 3);
      rv.ramp       = 1'b0;
      rv.extra_sync = 1'($urandom_range(0, 1));
      rv.start_mid  = 1'($urandom_range(0, 1));
      rv.stray      = 1'($urandom_range(0, 1));
      rv.stop_chirp = -1;
      rv.stop_at    = 0;
      rv.exp_outs   = CHIRPS * (SAMPLES - SKIP);
      rv.exp_done   = 1;
      rv.exp_err    = rv.extra_sync;
      rv.exp_ready  = CHIRPS * SAMPLES;
      run_frame(rv, $sformatf("rand%0d", n));
    end

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
